pe_sequencer: RTL and testbench

- Top-level controller for one PE datapath instance.
- Sequences the PE through five phases: register clear, filter/IF scratch load, read-address generation, partial-sum drain to the output buffer, completion.
- Also sequences the two-pass mode (mode==1).
- Sits between the array-level control and the datapath. It owns the datapath's start, clear and output-buffer-write control inputs and consumes the datapath's done flags.

---
 rtl/pe_ctrl_pkg.sv | 18 +
 rtl/pe_drain_counter.sv | 38 +++
 rtl/pe_sequencer.sv | 151 +++++++++++++++
 tb/tb_pe_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE sequencer: FSM state encoding and job mode codes.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        WAIT   = 3'd4,
        DRAIN  = 3'd5,
        DECIDE = 3'd6,
        DONE   = 3'd7
    } state_e;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_DUAL   = 2'd1;

endpackage

// File: rtl/pe_drain_counter.sv
// Counts output-buffer writes during a psum drain and flags when the
// requested number of entries will have been written at the end of this cycle.
module pe_drain_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] target,
    output logic         hit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] sum;

    always_comb begin
        sum   = cnt_q + W'(inc);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sum;
        end
        // cnt_q == target also covers a zero-length drain that sees a stray write
        hit = (sum == target) || (cnt_q == target);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// Job-level controller for one PE datapath: clear, scratch load, read-address
// generation, psum drain and pass accounting. All outputs are registered.
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int PSUM_SC_ADDR_LEN = 4,
    parameter int NUM_PASSES_DUAL  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [PSUM_SC_ADDR_LEN-1:0] psum_count,
    input  logic                        full_done,
    input  logic                        psum_sc_done,
    input  logic                        outbuf_write,
    input  logic                        outbuf_full,
    output logic                        regs_clr,
    output logic                        filter_read_start,
    output logic                        IF_read_start,
    output logic                        start_rd_gen,
    output logic                        outbuf_write_flag,
    output logic [1:0]                  mode_o,
    output logic                        busy,
    output logic                        done
);

    state_e                      state_q, state_d;
    logic [1:0]                  mode_q, mode_d;
    logic [PSUM_SC_ADDR_LEN-1:0] psum_count_q, psum_count_d;
    logic [1:0]                  pass_cnt_q, pass_cnt_d;
    logic                        full_seen_q, full_seen_d;
    logic                        regs_clr_q, regs_clr_d;
    logic                        load_q, load_d;
    logic                        rd_gen_q, rd_gen_d;
    logic                        flag_q, flag_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        drain_clear, drain_inc, drain_hit;
    logic [1:0]                  pass_inc, passes_req;
    logic                        unused_status;

    // The datapath throttles itself on a full output buffer; nothing to do here.
    assign unused_status = outbuf_full;

    pe_drain_counter #(.W(PSUM_SC_ADDR_LEN)) u_drain (
        .clk    (clk),
        .rst    (rst),
        .clear  (drain_clear),
        .inc    (drain_inc),
        .target (psum_count_q),
        .hit    (drain_hit)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        psum_count_d = psum_count_q;
        pass_cnt_d   = pass_cnt_q;
        full_seen_d  = full_seen_q;
        drain_clear  = 1'b0;
        drain_inc    = 1'b0;
        pass_inc     = pass_cnt_q + 2'd1;
        passes_req   = (mode_q == MODE_DUAL) ? 2'(NUM_PASSES_DUAL) : 2'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    psum_count_d = psum_count;
                    pass_cnt_d   = 2'd0;
                    state_d      = CLR;
                end
            end
            CLR: begin
                full_seen_d = 1'b0;
                state_d     = LOAD;
            end
            LOAD: state_d = RUN;
            RUN:  state_d = WAIT;
            WAIT: begin
                if (full_done) full_seen_d = 1'b1;
                if (psum_sc_done) begin
                    drain_clear = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (full_done) full_seen_d = 1'b1;
                drain_inc = outbuf_write;
                if (drain_hit) state_d = DECIDE;
            end
            DECIDE: begin
                if (!full_seen_q) begin
                    state_d = RUN;
                end else begin
                    pass_cnt_d = pass_inc;
                    state_d    = (pass_inc < passes_req) ? CLR : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        regs_clr_d = (state_d == CLR);
        load_d     = (state_d == LOAD);
        rd_gen_d   = (state_d == RUN);
        flag_d     = (state_d == DRAIN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= 2'd0;
            psum_count_q <= '0;
            pass_cnt_q   <= 2'd0;
            full_seen_q  <= 1'b0;
            regs_clr_q   <= 1'b0;
            load_q       <= 1'b0;
            rd_gen_q     <= 1'b0;
            flag_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            psum_count_q <= psum_count_d;
            pass_cnt_q   <= pass_cnt_d;
            full_seen_q  <= full_seen_d;
            regs_clr_q   <= regs_clr_d;
            load_q       <= load_d;
            rd_gen_q     <= rd_gen_d;
            flag_q       <= flag_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign regs_clr          = regs_clr_q;
    assign filter_read_start = load_q;
    assign IF_read_start     = load_q;
    assign start_rd_gen      = rd_gen_q;
    assign outbuf_write_flag = flag_q;
    assign mode_o            = mode_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized bench: a datapath-like driver issues jobs and pushes the expected
// event stream; a negedge monitor turns DUT outputs into events and compares.
module tb_pe_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] psum_count = '0;
    logic         full_done = 1'b0;
    logic         psum_sc_done = 1'b0;
    logic         outbuf_write = 1'b0;
    logic         outbuf_full = 1'b0;
    logic         regs_clr, filter_read_start, IF_read_start, start_rd_gen;
    logic         outbuf_write_flag, busy, done;
    logic [1:0]   mode_o;

    always #5 clk = ~clk;

    pe_sequencer #(.PSUM_SC_ADDR_LEN(W), .NUM_PASSES_DUAL(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .mode              (mode),
        .psum_count        (psum_count),
        .full_done         (full_done),
        .psum_sc_done      (psum_sc_done),
        .outbuf_write      (outbuf_write),
        .outbuf_full       (outbuf_full),
        .regs_clr          (regs_clr),
        .filter_read_start (filter_read_start),
        .IF_read_start     (IF_read_start),
        .start_rd_gen      (start_rd_gen),
        .outbuf_write_flag (outbuf_write_flag),
        .mode_o            (mode_o),
        .busy              (busy),
        .done              (done)
    );

    localparam int EV_CLR = 0, EV_LOAD = 1, EV_RDGEN = 2, EV_RISE = 3, EV_FALL = 4, EV_DONE = 5;
    typedef struct {int kind; int d1; int d2;} tok_t;
    tok_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   hung = 0;

    function automatic string ev_name(int k);
        case (k)
            EV_CLR:   return "clr";
            EV_LOAD:  return "load";
            EV_RDGEN: return "rdgen";
            EV_RISE:  return "flag_rise";
            EV_FALL:  return "flag_fall";
            EV_DONE:  return "done";
            default:  return "none";
        endcase
    endfunction

    function automatic void push(int k, int a, int b);
        tok_t t;
        t.kind = k; t.d1 = a; t.d2 = b;
        exp_q.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0, last_ev_cyc = 0, flag_start = 0, wr_cnt = 0;
    bit flag_prev = 0, done_prev = 0;

    task automatic observe(input int kind, input int a, input int b);
        tok_t e;
        last_ev_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL stray_event: got %s(%0d,%0d) at cycle %0d want no event", ev_name(kind), a, b, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || (e.d1 >= 0 && e.d1 != a) || (e.d2 >= 0 && e.d2 != b)) begin
            bad++;
            $display("FAIL event: got %s(%0d,%0d) at cycle %0d want %s(%0d,%0d)",
                     ev_name(kind), a, b, cyc, ev_name(e.kind), e.d1, e.d2);
        end else begin
            $display("ok   event %s(%0d,%0d) at cycle %0d", ev_name(kind), a, b, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            flag_prev   = 0;
            done_prev   = 0;
            wr_cnt      = 0;
            last_ev_cyc = cyc;
        end else begin
            if (done_prev) check("busy_after_done", int'(busy), 0);
            done_prev = done;
            if (regs_clr) observe(EV_CLR, cyc - last_ev_cyc, int'(busy));
            if (filter_read_start || IF_read_start)
                observe(EV_LOAD, cyc - last_ev_cyc, int'({filter_read_start, IF_read_start}));
            if (start_rd_gen) observe(EV_RDGEN, cyc - last_ev_cyc, int'(busy));
            if (outbuf_write_flag && !flag_prev) begin
                observe(EV_RISE, cyc - last_ev_cyc, 0);
                flag_start = cyc;
                wr_cnt     = 0;
            end
            if (outbuf_write_flag && outbuf_write) wr_cnt++;
            if (!outbuf_write_flag && flag_prev) observe(EV_FALL, wr_cnt, cyc - flag_start);
            if (done) observe(EV_DONE, cyc - last_ev_cyc, int'(mode_o));
            flag_prev = outbuf_write_flag;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(int sel);
        if (sel == 0) return start_rd_gen;
        return done;
    endfunction

    task automatic wait_for(input string what, input int sel, output bit ok);
        for (int i = 0; i < 80; i++) begin
            if (sig(sel)) begin
                ok = 1;
                return;
            end
            tick();
        end
        ok = 0;
        hung = 1;
        total++;
        bad++;
        $display("FAIL timeout_%s: got no event want event within 80 cycles", what);
    endtask

    function automatic logic [8:0] outs();
        return {regs_clr, filter_read_start, IF_read_start, start_rd_gen,
                outbuf_write_flag, mode_o, busy, done};
    endfunction

    // fm: 0 = full_done with psum_sc_done, 1 = earlier in WAIT, 2 = during DRAIN
    task automatic run_job(input int m, input int cnt, input bit hold, input int stall_at,
                           input int ns_fix, input int fm_fix);
        int passes, w, width;
        int ns[2];
        int fm[2];
        int gaps[16];
        bit ok, isfull;
        passes = (m == 1) ? 2 : 1;
        for (int p = 0; p < 2; p++) begin
            ns[p] = (ns_fix > 0) ? ns_fix : int'($urandom_range(1, 3));
            fm[p] = (fm_fix >= 0) ? fm_fix : int'($urandom_range(0, 2));
        end
        $display("job: mode=%0d psum_count=%0d passes=%0d steps=%0d/%0d hold=%0d stall=%0d",
                 m, cnt, passes, ns[0], ns[1], hold, stall_at);
        start = 1; mode = 2'(m); psum_count = W'(cnt);
        push(EV_CLR, -1, 1); push(EV_LOAD, 1, 3); push(EV_RDGEN, 1, 1);
        tick();
        if (!hold) start = 0;
        mode = 2'($urandom); psum_count = W'($urandom);
        for (int p = 0; p < passes; p++) begin
            for (int s = 0; s < ns[p]; s++) begin
                wait_for("rdgen", 0, ok);
                if (!ok) return;
                tick();
                isfull = (s == ns[p] - 1);
                w = (isfull && fm[p] == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                for (int i = 0; i < w; i++) begin
                    full_done = isfull && fm[p] == 1 && i == 0;
                    tick();
                end
                full_done = 0;
                width = (cnt == 0) ? 1 : 0;
                for (int k = 0; k < cnt; k++) begin
                    gaps[k] = (k == stall_at) ? 5 : int'($urandom_range(0, 2));
                    width += gaps[k] + 1;
                end
                push(EV_RISE, -1, -1);
                push(EV_FALL, cnt, width);
                if (!isfull) push(EV_RDGEN, 1, 1);
                else if (p + 1 < passes) begin
                    push(EV_CLR, 1, 1); push(EV_LOAD, 1, 3); push(EV_RDGEN, 1, 1);
                end else push(EV_DONE, 1, m);
                psum_sc_done = 1;
                full_done = isfull && fm[p] == 0;
                tick();
                psum_sc_done = 0;
                full_done = isfull && fm[p] == 2;
                if (cnt == 0) begin
                    tick();
                    full_done = 0;
                end
                for (int k = 0; k < cnt; k++) begin
                    for (int j = 0; j < gaps[k]; j++) begin
                        outbuf_full = (k == stall_at) ? 1'b1 : 1'($urandom_range(0, 1));
                        tick();
                        full_done = 0;
                    end
                    outbuf_full = 0;
                    outbuf_write = 1;
                    tick();
                    full_done = 0;
                    outbuf_write = 0;
                end
            end
        end
        wait_for("done", 1, ok);
        start = 0;
        if (!ok) return;
        tick();
        tick();
    endtask

    task automatic reset_mid_drain();
        bit ok;
        $display("job: reset during drain");
        start = 1; mode = 2'd0; psum_count = W'(4);
        push(EV_CLR, -1, 1); push(EV_LOAD, 1, 3); push(EV_RDGEN, 1, 1);
        tick();
        start = 0;
        wait_for("rdgen_rst", 0, ok);
        if (!ok) return;
        tick();
        psum_sc_done = 1;
        push(EV_RISE, -1, -1);
        tick();
        psum_sc_done = 0;
        outbuf_write = 1;
        tick();
        outbuf_write = 0;
        tick();
        #2 rst = 1;
        #1;
        check("outs_at_rst", int'(outs()), 0);
        check("queue_at_rst", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("outs_in_rst", int'(outs()), 0);
        end
        tick();
        rst = 0;
        repeat (5) tick();
        check("outs_after_rst", int'(outs()), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(outs()), 0);
        rst = 0;
        repeat (3) tick();
        check("idle_outputs", int'(outs()), 0);

        run_job(0, 3, 0, -1, 1, 0);
        if (!hung) run_job(1, 2, 0, -1, 1, -1);
        if (!hung) run_job(0, 4, 0, 1, 2, -1);
        if (!hung) run_job(0, 0, 0, -1, 2, 1);
        if (!hung) reset_mid_drain();
        if (!hung) run_job(0, 2, 0, -1, 1, 0);
        if (!hung) run_job(2, 3, 1, -1, 0, -1);
        if (!hung) run_job(1, 1, 0, -1, 0, -1);
        for (int n = 0; n < 12 && !hung; n++) begin
            int c;
            c = int'($urandom_range(0, 6));
            run_job(int'($urandom_range(0, 3)), c, 1'($urandom_range(0, 1)),
                    (c >= 2 && $urandom_range(0, 1) == 1) ? 1 : -1, 0, -1);
        end
        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
